// File: rtl/conv_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : conv_tx_pkg
// Description : Shared types, constants and helpers for the conv3d operand
//               transmitter (FSM state encoding, default data width, tile
//               size computation).
// Revision    : 1.0 - initial release
// ============================================================================
package conv_tx_pkg;

    // Transmitter job state
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } tx_state_t;

    // Default activation/weight word width
    localparam int c_def_dw = 32;

    // Beats per group: one beat per kernel tap per input channel of the group
    function automatic int tile_beats(input int kd, input int kh,
                                      input int kw, input int cin_g);
        return kd * kh * kw * cin_g;
    endfunction

endpackage
`default_nettype wire

// File: rtl/conv_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : conv_tx_fifo
// Description : First-word-fallthrough FIFO for operand words. A word pushed
//               into an empty FIFO appears on head_data the following cycle.
//               head_data reads 0 while empty.
// Ports       : clk, rst        - clock, asynchronous active-high reset
//               push_valid/ready/data - ingress handshake (ready = !full)
//               pop             - consume head word (ignored when empty)
//               empty           - no word buffered
//               head_data       - current head word
// Revision    : 1.0 - initial release
// ============================================================================
module conv_tx_fifo
    import conv_tx_pkg::*;
#(
    parameter int DW    = c_def_dw,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_valid,
    output logic          push_ready,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic          empty,
    output logic [DW-1:0] head_data
);

    localparam int c_aw = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_cw = c_aw + 1;

    logic [DW-1:0]   r_mem [DEPTH];
    logic [c_aw-1:0] r_wr_ptr;
    logic [c_aw-1:0] r_rd_ptr;
    logic [c_cw-1:0] r_count;

    logic w_full;
    logic w_push;
    logic w_pop;

    assign w_full     = (r_count == c_cw'(DEPTH));
    assign empty      = (r_count == '0);
    assign push_ready = !w_full;
    assign w_push     = push_valid && !w_full;
    // Popping an empty FIFO is a no-op, so a word pushed this cycle into an
    // empty FIFO cannot be consumed before it is visible.
    assign w_pop      = pop && !empty;
    assign head_data  = empty ? '0 : r_mem[r_rd_ptr];

    // Storage carries no reset; only pointers and occupancy define validity.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == c_aw'(DEPTH - 1)) ? '0 : r_wr_ptr + c_aw'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == c_aw'(DEPTH - 1)) ? '0 : r_rd_ptr + c_aw'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_cw'(1);
                2'b01:   r_count <= r_count - c_cw'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/conv3d_operand_tx.sv
`default_nettype none
// ============================================================================
// Module      : conv3d_operand_tx
// Description : Streams paired activation/weight operands to a 3D-convolution
//               operator. A job is GROUPS tiles of KD*KH*KW*CIN_G beats; the
//               last beat of each tile is flagged and group_idx advances.
//               Operands are buffered in two FWFT FIFOs that accept words in
//               any state; beats are only issued while a job is running.
// Ports       : clk, rst                     - clock, async active-high reset
//               start / busy / done          - job control and status
//               act_valid/ready/data         - activation ingress
//               wgt_valid/ready/data         - weight ingress
//               valid_out / ready_in         - operator handshake
//               input_data / weight_data     - operand pair to the operator
//               last_out / group_idx         - tile end flag, current group
//               beat_count                   - beats in current/last job
//                                              (only with CONV_TX_STATS_EN)
// Options     : define CONV_TX_STATS_EN to add the beat_count statistics port
// Revision    : 1.0 - initial release
// ============================================================================
module conv3d_operand_tx
    import conv_tx_pkg::*;
#(
    parameter int DW         = c_def_dw,
    parameter int KD         = 3,
    parameter int KH         = 3,
    parameter int KW         = 3,
    parameter int CIN_G      = 2,
    parameter int GROUPS     = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          busy,
    output logic          done,
    input  logic          act_valid,
    output logic          act_ready,
    input  logic [DW-1:0] act_data,
    input  logic          wgt_valid,
    output logic          wgt_ready,
    input  logic [DW-1:0] wgt_data,
    output logic          valid_out,
    input  logic          ready_in,
    output logic [DW-1:0] input_data,
    output logic [DW-1:0] weight_data,
    output logic          last_out,
`ifdef CONV_TX_STATS_EN
    output logic [31:0]   beat_count,
`endif
    output logic [7:0]    group_idx
);

    localparam int c_tile = tile_beats(KD, KH, KW, CIN_G);
    localparam int c_bw   = (c_tile > 1) ? $clog2(c_tile) : 1;

    tx_state_t       r_state;
    logic [c_bw-1:0] r_beat;
    logic [7:0]      r_group;
    logic            r_busy;
    logic            r_done;
`ifdef CONV_TX_STATS_EN
    logic [31:0]     r_beat_count;
`endif

    logic w_act_empty;
    logic w_wgt_empty;
    logic w_fire;
    logic w_tile_end;

    conv_tx_fifo #(
        .DW    (DW),
        .DEPTH (FIFO_DEPTH)
    ) u_act_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_valid (act_valid),
        .push_ready (act_ready),
        .push_data  (act_data),
        .pop        (w_fire),
        .empty      (w_act_empty),
        .head_data  (input_data)
    );

    conv_tx_fifo #(
        .DW    (DW),
        .DEPTH (FIFO_DEPTH)
    ) u_wgt_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_valid (wgt_valid),
        .push_ready (wgt_ready),
        .push_data  (wgt_data),
        .pop        (w_fire),
        .empty      (w_wgt_empty),
        .head_data  (weight_data)
    );

    // A beat needs both operands; buffered words are held back outside RUN.
    assign valid_out  = (r_state == ST_RUN) && !w_act_empty && !w_wgt_empty;
    assign w_fire     = valid_out && ready_in;
    assign w_tile_end = (r_beat == c_bw'(c_tile - 1));
    assign last_out   = valid_out && w_tile_end;
    assign group_idx  = r_group;
    assign busy       = r_busy;
    assign done       = r_done;
`ifdef CONV_TX_STATS_EN
    assign beat_count = r_beat_count;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_beat       <= '0;
            r_group      <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
`ifdef CONV_TX_STATS_EN
            r_beat_count <= '0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_state      <= ST_RUN;
                        r_busy       <= 1'b1;
                        r_beat       <= '0;
                        r_group      <= '0;
`ifdef CONV_TX_STATS_EN
                        r_beat_count <= '0;
`endif
                    end
                end
                ST_RUN: begin
                    if (w_fire) begin
`ifdef CONV_TX_STATS_EN
                        r_beat_count <= r_beat_count + 32'd1;
`endif
                        if (w_tile_end) begin
                            r_beat  <= '0;
                            r_group <= r_group + 8'd1;
                            if (r_group == 8'(GROUPS - 1)) begin
                                r_state <= ST_DONE;
                                r_busy  <= 1'b0;
                                r_done  <= 1'b1;
                            end
                        end else begin
                            r_beat <= r_beat + c_bw'(1);
                        end
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
